// File: rtl/k12a_spi_pkg.sv
// Shared types and constants for the k12a SPI master.
package k12a_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // mode is packed as {CPOL, CPHA}
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/k12a_spi_clkgen.sv
// SCK half-period timer: emits a one-cycle tick every div+1 enabled cycles
// and tracks whether the next SCK edge is a leading or trailing one.
module k12a_spi_clkgen
  import k12a_spi_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sck_en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 lead
);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 phase;

  assign tick = en && (cnt == div);
  assign lead = ~phase;

  // Half-period counter, parked at zero whenever no transfer is running.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!en || (cnt == div))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Edge phase: the first tick of the SCK train is always a leading edge.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset)
      phase <= 1'b0;
    else if (!sck_en)
      phase <= 1'b0;
    else if (tick)
      phase <= ~phase;
  end

endmodule

// File: rtl/k12a_spi_master.sv
// k12a SPI master: sequencing FSM, edge counter, shift registers, CS decode.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last values
// SETUP | CS asserted, SCK at CPOL, one half-period before the first edge
// XFER  | SCK toggles on every tick, 2*WIDTH edges
// HOLD  | SCK back at CPOL, CS still asserted for one half-period
// DONE  | CS released, rx_data loaded, done pulse; may accept a new start
module k12a_spi_master
  import k12a_spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CS    = 1,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic [2:0]           cs_sel,
  input  logic [1:0]           mode,
  input  logic                 lsb_first,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic [NUM_CS-1:0]    spi_cs_n
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_SETUP = SETUP;
  localparam logic [2:0] S_XFER  = XFER;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_DONE  = DONE;

  localparam int EW = $clog2(2*WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*WIDTH-1);

  logic [2:0]           state, state_nxt;
  logic [1:0]           mode_q;
  logic                 lsb_q;
  logic [2:0]           cs_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [EW-1:0]        edge_cnt;
  logic [WIDTH-1:0]     tx_sh, rx_sh;
  logic                 tick, lead, accept, clk_en, sck_en, active_nxt;
  logic [2:0]           cs_idx_nxt;
  logic [NUM_CS-1:0]    cs_n_nxt;

  function automatic logic out_bit(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign clk_en     = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
  assign sck_en     = (state == S_XFER);
  assign active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_XFER) || (state_nxt == S_HOLD);
  assign cs_idx_nxt = accept ? cs_sel : cs_q;

  k12a_spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .en        (clk_en),
    .sck_en    (sck_en),
    .div       (div_q),
    .tick      (tick),
    .lead      (lead)
  );

  // Next-state sequencing; DONE can chain straight into SETUP.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (tick) state_nxt = S_XFER;
      S_XFER:  if (tick && (edge_cnt == LAST_EDGE)) state_nxt = S_HOLD;
      S_HOLD:  if (tick) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SETUP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Chip-select decode; an out-of-range index leaves every select high.
  always_comb begin
    cs_n_nxt = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (active_nxt && (cs_idx_nxt == 3'(i)))
        cs_n_nxt[i] = 1'b0;
    end
  end

  // Registered state, configuration, shifting and all outputs.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_q   <= SPI_MODE0;
      lsb_q    <= 1'b0;
      cs_q     <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      state    <= state_nxt;
      busy     <= active_nxt;
      done     <= (state_nxt == S_DONE);
      spi_cs_n <= cs_n_nxt;
      if (accept) begin
        mode_q   <= mode;
        lsb_q    <= lsb_first;
        cs_q     <= cs_sel;
        div_q    <= clk_div;
        edge_cnt <= '0;
        rx_sh    <= '0;
        spi_sck  <= mode[CPOL_BIT];
        // CPHA=0 slaves sample on the first edge, so bit 0 must already be out.
        if (!mode[CPHA_BIT]) begin
          spi_mosi <= out_bit(tx_data, lsb_first);
          tx_sh    <= shift_out(tx_data, lsb_first);
        end else begin
          tx_sh    <= tx_data;
        end
      end else if (sck_en && tick) begin
        edge_cnt <= edge_cnt + 1'b1;
        spi_sck  <= ~spi_sck;
        if (lead != mode_q[CPHA_BIT]) begin
          rx_sh <= lsb_q ? {spi_miso, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], spi_miso};
        end else if (edge_cnt != LAST_EDGE) begin
          // The final CPHA=0 trailing edge has no bit left; MOSI keeps the last one.
          spi_mosi <= out_bit(tx_sh, lsb_q);
          tx_sh    <= shift_out(tx_sh, lsb_q);
        end
      end
      if ((state == S_HOLD) && tick)
        rx_data <= rx_sh;
    end
  end

endmodule

// File: tb/tb_k12a_spi_master.sv
// Scoreboard bench for k12a_spi_master: an 8-bit single-CS instance and a
// 16-bit four-CS instance share clock and reset.
`timescale 1ns/1ps
module tb_k12a_spi_master;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] mosi;
    int          busy;
    int          width;
    logic [1:0]  mode;
    logic [3:0]  cs;
  } exp_t;

  logic        cpu_clock = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  tx8 = '0;
  logic [15:0] tx16 = '0;
  logic [2:0]  cs_sel = '0;
  logic [1:0]  mode = '0;
  logic        lsb_first = 1'b0;
  logic [7:0]  clk_div = '0;
  logic        busy8, done8, sck8, mosi8, miso8;
  logic        busy16, done16, sck16, mosi16, miso16;
  logic [7:0]  rx8;
  logic [15:0] rx16;
  logic [0:0]  csn8;
  logic [3:0]  csn16;
  logic        loop8 = 1'b1;
  logic [7:0]  slv8 = '0;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] s_rx[2];
  logic        s_busy[2], s_done[2], s_sck[2], s_mosi[2];
  logic [3:0]  s_cs[2];

  int          busy_cnt[2], edges[2], cs_bad[2];
  logic [31:0] samp[2];
  logic [31:0] seq[2];
  logic        pbusy[2], psck[2];
  logic [2:0]  sidx8;

  always #5 cpu_clock = ~cpu_clock;

  k12a_spi_master #(.WIDTH(8), .NUM_CS(1), .DIV_WIDTH(8)) u8 (
    .cpu_clock(cpu_clock), .reset(rst), .start(start8), .tx_data(tx8),
    .cs_sel(cs_sel), .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div),
    .busy(busy8), .done(done8), .rx_data(rx8), .spi_sck(sck8),
    .spi_mosi(mosi8), .spi_miso(miso8), .spi_cs_n(csn8));

  k12a_spi_master #(.WIDTH(16), .NUM_CS(4), .DIV_WIDTH(8)) u16 (
    .cpu_clock(cpu_clock), .reset(rst), .start(start16), .tx_data(tx16),
    .cs_sel(cs_sel), .mode(mode), .lsb_first(lsb_first), .clk_div(clk_div),
    .busy(busy16), .done(done16), .rx_data(rx16), .spi_sck(sck16),
    .spi_mosi(mosi16), .spi_miso(miso16), .spi_cs_n(csn16));

  // Slave model: either loopback or a fixed word shifted out in lsb_first order.
  assign sidx8  = lsb_first ? samp[0][2:0] : (3'd7 - samp[0][2:0]);
  assign miso8  = loop8 ? mosi8 : slv8[sidx8];
  assign miso16 = mosi16;

  assign s_rx[0] = {24'b0, rx8};   assign s_rx[1] = {16'b0, rx16};
  assign s_busy[0] = busy8;        assign s_busy[1] = busy16;
  assign s_done[0] = done8;        assign s_done[1] = done16;
  assign s_sck[0] = sck8;          assign s_sck[1] = sck16;
  assign s_mosi[0] = mosi8;        assign s_mosi[1] = mosi16;
  assign s_cs[0] = {3'b111, csn8}; assign s_cs[1] = csn16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: accumulates per-frame observations and scores them on each done pulse.
  always @(negedge cpu_clock) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy_cnt[d] = 0; edges[d] = 0; cs_bad[d] = 0; samp[d] = 0; seq[d] = 0;
        pbusy[d] = 1'b0; psck[d] = 1'b0;
      end else begin
        exp_t e;
        bit   has;
        has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) e = (d == 0) ? q0[0] : q1[0];
        if (s_busy[d]) begin
          busy_cnt[d]++;
          if (has && (s_cs[d] !== e.cs)) cs_bad[d]++;
          if (pbusy[d] && (s_sck[d] != psck[d])) begin
            edges[d]++;
            if (has && ((s_sck[d] != e.mode[1]) == !e.mode[0])) begin
              seq[d] = {seq[d][30:0], s_mosi[d]};
              samp[d] = samp[d] + 1;
            end
          end
        end
        if (s_done[d]) begin
          if (!has) begin
            checks++; errors++;
            $display("FAIL unexpected_done dut=%0d actual=1 expected=0", d);
          end else begin
            logic [31:0] m;
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            m = (e.width == 32) ? 32'hFFFF_FFFF : ((32'd1 << e.width) - 1);
            chk($sformatf("rx_data dut%0d", d), s_rx[d], e.rx);
            chk($sformatf("busy_cycles dut%0d", d), busy_cnt[d], e.busy);
            chk($sformatf("sck_edges dut%0d", d), edges[d], 2 * e.width);
            chk($sformatf("mosi_bits dut%0d", d), seq[d] & m, e.mosi);
            chk($sformatf("cs_during_busy dut%0d", d), cs_bad[d], 0);
            chk($sformatf("cs_released dut%0d", d), {28'b0, s_cs[d]}, 32'hF);
          end
          busy_cnt[d] = 0; edges[d] = 0; cs_bad[d] = 0; samp[d] = 0; seq[d] = 0;
        end
        pbusy[d] = s_busy[d];
        psck[d]  = s_sck[d];
      end
    end
  end

  // Issue one transfer; caller must be sitting at a falling edge.
  task automatic run(input int d, input logic [31:0] txv, input logic [1:0] m,
                     input logic lsb, input logic [7:0] div, input logic [2:0] cs,
                     input logic lp, input logic [7:0] slave, input logic [31:0] erx,
                     input logic [31:0] emosi, input logic [3:0] ecs, input bit push_exp);
    exp_t e;
    #1;
    e.rx = erx; e.mosi = emosi; e.mode = m; e.cs = ecs;
    e.width = (d == 0) ? 8 : 16;
    e.busy = (2 * e.width + 2) * (int'(div) + 1);
    if (push_exp) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    mode = m; lsb_first = lsb; clk_div = div; cs_sel = cs; loop8 = lp; slv8 = slave;
    if (d == 0) begin tx8 = txv[7:0]; start8 = 1'b1; end
    else begin tx16 = txv[15:0]; start16 = 1'b1; end
    @(negedge cpu_clock); #1;
    start8 = 1'b0; start16 = 1'b0;
  endtask

  task automatic wait_done(input int d, input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge cpu_clock);
      if ((d == 0) ? done8 : done16) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout %s actual=no_done expected=done", name);
    end
  endtask

  initial begin
    int dcount;
    repeat (3) @(negedge cpu_clock);
    chk("reset busy8", {31'b0, busy8}, 0);
    chk("reset done8", {31'b0, done8}, 0);
    chk("reset cs8", {31'b0, csn8}, 1);
    chk("reset cs16", {28'b0, csn16}, 32'hF);
    chk("reset sck16", {31'b0, sck16}, 0);
    chk("reset rx16", {16'b0, rx16}, 0);
    rst = 1'b0;
    @(negedge cpu_clock);

    // Mode 0, loopback, A5 MSB first
    run(0, 32'hA5, 2'b00, 1'b0, 8'd0, 3'd0, 1'b1, 8'h00, 32'hA5, 32'hA5, 4'hE, 1);
    wait_done(0, "mode0_a5");
    repeat (2) @(negedge cpu_clock);

    // Mode 3, div 2, LSB first, slave returns 0x81
    run(0, 32'h3C, 2'b11, 1'b1, 8'd2, 3'd0, 1'b0, 8'h81, 32'h81, 32'h3C, 4'hE, 1);
    wait_done(0, "mode3_3c");
    chk("mode3 sck idle", {31'b0, sck8}, 1);
    repeat (2) @(negedge cpu_clock);

    // Restart mid-transfer is ignored; start in the done cycle chains directly
    run(0, 32'h5A, 2'b00, 1'b0, 8'd1, 3'd0, 1'b1, 8'h00, 32'h5A, 32'h5A, 4'hE, 1);
    repeat (8) @(negedge cpu_clock);
    #1; tx8 = 8'hFF; start8 = 1'b1;
    @(negedge cpu_clock); #1; start8 = 1'b0;
    wait_done(0, "restart_5a");
    run(0, 32'hC6, 2'b00, 1'b0, 8'd0, 3'd0, 1'b1, 8'h00, 32'hC6, 32'hC6, 4'hE, 1);
    chk("b2b busy", {31'b0, busy8}, 1);
    chk("b2b cs", {31'b0, csn8}, 0);
    wait_done(0, "b2b_c6");
    repeat (2) @(negedge cpu_clock);

    // Reset at edge 7 of an FF frame
    run(0, 32'hFF, 2'b00, 1'b0, 8'd0, 3'd0, 1'b1, 8'h00, 32'h0, 32'h0, 4'hE, 0);
    repeat (6) @(posedge cpu_clock);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", {31'b0, busy8}, 0);
    chk("rst done", {31'b0, done8}, 0);
    chk("rst rx", {24'b0, rx8}, 0);
    chk("rst sck", {31'b0, sck8}, 0);
    chk("rst mosi", {31'b0, mosi8}, 0);
    chk("rst cs", {31'b0, csn8}, 1);
    @(negedge cpu_clock); #1 rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cpu_clock);
      if (done8) dcount++;
    end
    chk("no done after reset", dcount, 0);
    run(0, 32'h96, 2'b10, 1'b0, 8'd0, 3'd0, 1'b1, 8'h00, 32'h96, 32'h96, 4'hE, 1);
    wait_done(0, "post_reset_96");
    repeat (2) @(negedge cpu_clock);

    // WIDTH=16, cs_sel=2, mode 1
    run(1, 32'hC3A5, 2'b01, 1'b0, 8'd0, 3'd2, 1'b1, 8'h00, 32'hC3A5, 32'hC3A5, 4'b1011, 1);
    wait_done(1, "w16_cs2");
    repeat (2) @(negedge cpu_clock);

    // cs_sel out of range: dummy clocks, no select
    run(1, 32'h1234, 2'b00, 1'b0, 8'd1, 3'd5, 1'b1, 8'h00, 32'h1234, 32'h1234, 4'b1111, 1);
    wait_done(1, "w16_cs5");
    repeat (3) @(negedge cpu_clock);

    chk("queue8 drained", q0.size(), 0);
    chk("queue16 drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/k12a_spi_master.md
# k12a_spi_master

Parametrised SPI master peripheral for the k12a system, succeeding the fixed single-byte, mode-0, single-device SPI pins of the current I/O block. It supports a configurable frame width, all four CPOL/CPHA modes, MSB- or LSB-first shifting, a programmable SCK divider and up to eight chip selects. It sits behind the I/O decoder on `cpu_clock`, driven by a start strobe. It reports completion through `busy`/`done`, which can also feed `wake_sources`.

## Interface
- `WIDTH`, 8: frame length in bits, legal 4..32.
- `NUM_CS`, 1: number of chip-select outputs, legal 1..8.
- `DIV_WIDTH`, 8: width of `clk_div`.

- `cpu_clock` in 1: the block's one clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a transfer; sampled only when idle.
- `tx_data` in `WIDTH`: frame to transmit, latched at accepted start.
- `cs_sel` in 3: chip-select index, latched at start.
- `mode` in 2: {CPOL, CPHA}, latched at start.
- `lsb_first` in 1: 1 selects LSB-first shifting, latched at start.
- `clk_div` in `DIV_WIDTH`: SCK half-period is `clk_div`+1 cycles, latched at start.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `rx_data` out `WIDTH`: last received frame.
- `spi_sck` out 1: serial clock.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.
- `spi_cs_n` out `NUM_CS`: active-low chip selects.

## Operation
- States: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE, `start`=1: latch all configuration and `tx_data` into the shift register, then go to SETUP.
- `start` in any other state is ignored; there is no queueing.
- Define H = latched `clk_div`+1 cycles.
- SETUP (H cycles):
  - `spi_cs_n[cs_sel]` low.
  - SCK held at CPOL.
  - CPHA=0: first bit is on MOSI.
- XFER (2·WIDTH·H cycles): SCK toggles every H cycles, giving 2·WIDTH edges.
  - CPHA=0: sample MISO on leading edges; shift the next bit out on trailing edges.
  - CPHA=1: shift out on leading edges (first bit appears at the first leading edge); sample on trailing edges.
- HOLD (H cycles): SCK back at CPOL, CS still asserted.
- DONE (1 cycle):
  - CS deasserted.
  - `rx_data` loaded.
  - `done`=1.
  - `busy`=0.
  - Return to IDLE.
- Received bits assemble MSB-first or LSB-first to mirror the `lsb_first` transmit order.
- `cs_sel` ≥ `NUM_CS`: all `spi_cs_n` stay high, and the transfer still runs with full timing (dummy clocks).
- `clk_div`=0: H=1, so SCK runs at `cpu_clock`/2.
- Divider counter wraps from `clk_div` to 0 on each tick; it is never free-running outside a transfer.
- MOSI in IDLE holds the last driven bit.

## Timing
- Accepted start at edge 0 → `busy`=1 from edge 1 through edge (2·WIDTH+2)·H.
- `done` and `rx_data` update at edge (2·WIDTH+2)·H+1, when `busy` falls.
- A new `start` may be accepted in the cycle `done` is high (back-to-back); CS then re-asserts on the next edge.
- Reset (asynchronous, any time, including mid-transfer): all outputs return to their reset values immediately, and the FSM returns to IDLE. Reset values:
  - `busy`=0, `done`=0.
  - `rx_data`=0.
  - `spi_sck`=0, `spi_mosi`=0.
  - `spi_cs_n` all 1.
  - Latched mode = 00.
  - A partial frame is discarded.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Structure
- Package `k12a_spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, XFER, HOLD, DONE).
  - `SPI_MODE0`..`SPI_MODE3` constants.
  - CPOL/CPHA bit-index constants.
- Sub-module `k12a_spi_clkgen`:
  - DIV_WIDTH-bit half-period counter.
  - Outputs a one-cycle `tick` and a leading/trailing edge flag.
  - Enabled only outside IDLE/DONE.
- Top module contains the FSM, the edge counter (clog2(2·WIDTH+1) bits), the shift-out and shift-in registers, and CS decode.

## Test plan
- Mode 0, WIDTH=8, `clk_div`=0, `tx_data`=0xA5, MISO looped to MOSI → 8 SCK pulses, MOSI bits 1,0,1,0,0,1,0,1; `busy` high exactly 18 cycles; `done` pulse; `rx_data`=0xA5.
- Mode 3, `clk_div`=2, `lsb_first`=1, `tx_data`=0x3C, MISO driven by a model returning 0x81 → SCK idles high; 54 busy cycles; MOSI order 0,0,1,1,1,1,0,0; `rx_data`=0x81.
- WIDTH=16, `NUM_CS`=4, `cs_sel`=2, mode 1 → only `spi_cs_n[2]` low, from edge 1 to edge 34; 16 data bits with correct phase.
- `start` re-pulsed mid-transfer with a different `tx_data` → ignored; original frame completes; a second start in the `done` cycle is accepted with zero idle gap.
- `reset` asserted at edge 7 of a transfer → outputs at reset values immediately; no `done`; the next start produces a clean full frame.
- `cs_sel`=5 with `NUM_CS`=4 → no CS asserts; full SCK train; `done` after (2·WIDTH+2)·H cycles.
